// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: default width, op selects,
// flag bit positions and FSM state encoding.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_AND     = 3'b010;
  localparam logic [2:0] OP_OR      = 3'b011;
  localparam logic [2:0] OP_XOR     = 3'b100;
  localparam logic [2:0] OP_SHL     = 3'b101;
  localparam logic [2:0] OP_SHR     = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  // Bit positions within the {ovf,neg,zero,carry} flag vector.
  localparam int unsigned FLAG_CARRY = 0;
  localparam int unsigned FLAG_ZERO  = 1;
  localparam int unsigned FLAG_NEG   = 2;
  localparam int unsigned FLAG_OVF   = 3;
  localparam int unsigned NUM_FLAGS  = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/alu_cmd_driver.sv
// Initiator for the 8-bit ALU: one command in flight, registered ALU operands, fixed-latency
// result capture, accumulator chaining. Optional STICKY_FLAGS_EN adds sticky flag tracking.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = ALU_WIDTH,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  input  logic                 cmd_use_acc,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [2:0]           alu_sel,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic [NUM_FLAGS-1:0] alu_flags,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_data,
  output logic [NUM_FLAGS-1:0] rsp_flags,
  output logic                 rsp_err,
  output logic [CNT_W-1:0]     op_count
`ifdef STICKY_FLAGS_EN
  ,
  input  logic                 sticky_clr,
  output logic [NUM_FLAGS-1:0] sticky_flags
`endif
);

  localparam int unsigned LatW = $clog2(ALU_LAT + 1);

  state_e               state_q, state_d;
  logic [LatW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]           alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0]     acc_q, acc_d, rsp_data_q, rsp_data_d;
  logic [NUM_FLAGS-1:0] rsp_flags_q, rsp_flags_d;
  logic                 rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]     op_count_q, op_count_d;
  logic                 capture;

  assign cmd_ready = (state_q == StIdle);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;
  assign op_count  = op_count_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    acc_d       = acc_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    op_count_d  = op_count_q;
    capture     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_op == OP_ILLEGAL) begin
            // Rejected without touching the ALU: error response on the next cycle.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            rsp_flags_d = '0;
            state_d     = StResp;
          end else begin
            alu_a_d   = cmd_use_acc ? acc_q : cmd_a;
            alu_b_d   = cmd_b;
            alu_sel_d = cmd_op;
            cnt_d     = LatW'(ALU_LAT);
            state_d   = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - LatW'(1);
        if (cnt_q == LatW'(1)) begin
          capture = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (capture) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b0;
      rsp_data_d  = alu_out;
      rsp_flags_d = alu_flags;
      acc_d       = alu_out;
      op_count_d  = op_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      acc_q       <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      acc_q       <= acc_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      op_count_q  <= op_count_d;
    end
  end

`ifdef STICKY_FLAGS_EN
  logic [NUM_FLAGS-1:0] sticky_q;

  // Clear takes priority over a same-cycle capture.
  always_ff @(posedge clk) begin
    if (rst || sticky_clr) begin
      sticky_q <= '0;
    end else if (capture) begin
      sticky_q <= sticky_q | alu_flags;
    end
  end

  assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Randomized bench for alu_cmd_driver: two instances (ALU_LAT=1/CNT_W=16 and ALU_LAT=3/CNT_W=4)
// behind an adder stub, checked against a transaction-level reference model.
module tb_alu_cmd_driver;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, sel, cmd_valid, rsp_ready, cmd_use_acc;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;

  logic        cr0, rv0, re0, cr1, rv1, re1;
  logic [7:0]  aa0, ab0, rd0, ao0, aa1, ab1, rd1, ao1;
  logic [2:0]  as0, as1;
  logic [3:0]  rf0, af0, rf1, af1;
  logic [15:0] oc0;
  logic [3:0]  oc1;

  logic        cmd_ready, rsp_valid, rsp_err;
  logic [7:0]  alu_a, alu_b, rsp_data;
  logic [2:0]  alu_sel;
  logic [3:0]  rsp_flags;
  logic [15:0] op_count;

`ifdef STICKY_FLAGS_EN
  logic       sticky_clr, clr_at_cap;
  logic [3:0] sf0, sf1, sticky_flags, m_sticky;
  assign sticky_flags = sel ? sf1 : sf0;
`endif

  function automatic logic [3:0] stub_flags(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return {(a[7] == b[7]) && (s[7] != a[7]), s[7], s[7:0] == 8'h00, s[8]};
  endfunction

  assign ao0 = aa0 + ab0;
  assign af0 = stub_flags(aa0, ab0);
  assign ao1 = aa1 + ab1;
  assign af1 = stub_flags(aa1, ab1);

  assign cmd_ready = sel ? cr1 : cr0;
  assign rsp_valid = sel ? rv1 : rv0;
  assign rsp_err   = sel ? re1 : re0;
  assign alu_a     = sel ? aa1 : aa0;
  assign alu_b     = sel ? ab1 : ab0;
  assign alu_sel   = sel ? as1 : as0;
  assign rsp_data  = sel ? rd1 : rd0;
  assign rsp_flags = sel ? rf1 : rf0;
  assign op_count  = sel ? {12'h000, oc1} : oc0;

  alu_cmd_driver #(.WIDTH(8), .ALU_LAT(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid & ~sel), .cmd_ready(cr0), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .alu_a(aa0), .alu_b(ab0),
    .alu_sel(as0), .alu_out(ao0), .alu_flags(af0), .rsp_valid(rv0),
    .rsp_ready(rsp_ready & ~sel), .rsp_data(rd0), .rsp_flags(rf0), .rsp_err(re0),
    .op_count(oc0)
`ifdef STICKY_FLAGS_EN
    , .sticky_clr(sticky_clr), .sticky_flags(sf0)
`endif
  );

  alu_cmd_driver #(.WIDTH(8), .ALU_LAT(3), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid & sel), .cmd_ready(cr1), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .alu_a(aa1), .alu_b(ab1),
    .alu_sel(as1), .alu_out(ao1), .alu_flags(af1), .rsp_valid(rv1),
    .rsp_ready(rsp_ready & sel), .rsp_data(rd1), .rsp_flags(rf1), .rsp_err(re1),
    .op_count(oc1)
`ifdef STICKY_FLAGS_EN
    , .sticky_clr(sticky_clr), .sticky_flags(sf1)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int lat, cnt_mod, m_acc, m_cnt;
  logic [7:0] m_alu_a, m_alu_b;
  logic [2:0] m_alu_sel;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference flags from signed/unsigned integer arithmetic.
  function automatic logic [3:0] ref_flags(input int x, input int y);
    int s, d, sx, sy, ss;
    s  = x + y;
    d  = s % 256;
    sx = (x >= 128) ? x - 256 : x;
    sy = (y >= 128) ? y - 256 : y;
    ss = sx + sy;
    return {(ss > 127) || (ss < -128), d >= 128, d == 0, s > 255};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_acc = 0; m_cnt = 0; m_alu_a = '0; m_alu_b = '0; m_alu_sel = '0;
`ifdef STICKY_FLAGS_EN
    m_sticky = '0;
`endif
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic use_acc, input int hold);
    int ea;
    logic [7:0] ed;
    logic [3:0] ef;
    check_val("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc;
    step();
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
    cmd_use_acc = 1'($urandom);
    if (op == OP_ILLEGAL) begin
      ed = '0;
      ef = '0;
    end else begin
      ea = use_acc ? m_acc : int'(a);
      ed = 8'((ea + int'(b)) % 256);
      ef = ref_flags(ea, int'(b));
      m_alu_a = 8'(ea); m_alu_b = b; m_alu_sel = op;
      for (int k = 1; k <= lat; k++) begin
        check_val("alu_a_issue", alu_a, m_alu_a);
        check_val("alu_b_issue", alu_b, m_alu_b);
        check_val("alu_sel_issue", alu_sel, m_alu_sel);
        check_val("rsp_valid_wait", rsp_valid, 0);
        check_val("cmd_ready_wait", cmd_ready, 0);
`ifdef STICKY_FLAGS_EN
        if (k == lat && clr_at_cap) sticky_clr = 1'b1;
`endif
        step();
      end
`ifdef STICKY_FLAGS_EN
      sticky_clr = 1'b0;
      m_sticky = clr_at_cap ? 4'h0 : (m_sticky | ef);
`endif
      m_acc = int'(ed);
      m_cnt = (m_cnt + 1) % cnt_mod;
    end
    for (int h = 0; h <= hold; h++) begin
      check_val("rsp_valid", rsp_valid, 1);
      check_val("rsp_data", rsp_data, ed);
      check_val("rsp_flags", rsp_flags, ef);
      check_val("rsp_err", rsp_err, op == OP_ILLEGAL);
      check_val("cmd_ready_resp", cmd_ready, 0);
      check_val("alu_a_hold", alu_a, m_alu_a);
      check_val("alu_sel_hold", alu_sel, m_alu_sel);
      check_val("op_count", op_count, m_cnt);
`ifdef STICKY_FLAGS_EN
      check_val("sticky_flags", sticky_flags, m_sticky);
`endif
      if (h < hold) step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_val("rsp_valid_done", rsp_valid, 0);
    check_val("rsp_err_done", rsp_err, 0);
    check_val("cmd_ready_done", cmd_ready, 1);
  endtask

  task automatic check_reset_state();
    check_val("rst_cmd_ready", cmd_ready, 1);
    check_val("rst_alu_a", alu_a, 0);
    check_val("rst_alu_b", alu_b, 0);
    check_val("rst_alu_sel", alu_sel, 0);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_rsp_data", rsp_data, 0);
    check_val("rst_rsp_flags", rsp_flags, 0);
    check_val("rst_rsp_err", rsp_err, 0);
    check_val("rst_op_count", op_count, 0);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_use_acc = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0;
`ifdef STICKY_FLAGS_EN
    sticky_clr = 1'b0; clr_at_cap = 1'b0;
`endif
    lat = 1; cnt_mod = 65536;
    do_reset(2);
    check_reset_state();

    // Latency-1 instance: directed chain, then random traffic including illegal ops.
    do_op(OP_ADD, 8'd10, 8'd5, 1'b0, 5);
    do_op(OP_ADD, 8'd99, 8'd1, 1'b1, 0);
    do_op(OP_ADD, 8'd200, 8'd100, 1'b0, 1);
    do_op(OP_ILLEGAL, 8'd3, 8'd4, 1'b0, 2);
    do_op(OP_ADD, 8'd0, 8'd0, 1'b1, 0);
    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(7, 0)), 8'($urandom), 8'($urandom), 1'($urandom),
            int'($urandom_range(3, 0)));
    end

    // Latency-3 instance with a 4-bit counter.
    sel = 1'b1; lat = 3; cnt_mod = 16;
    do_reset(1);
    check_reset_state();
    do_op(OP_ADD, 8'd20, 8'd30, 1'b0, 0);
    do_op(OP_XOR, 8'd1, 8'd2, 1'b1, 1);

    // Reset while waiting on the ALU: op is dropped and no response appears.
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = 8'd7; cmd_b = 8'd9; cmd_use_acc = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    check_val("midwait_cmd_ready", cmd_ready, 0);
    do_reset(1);
    check_reset_state();
    for (int i = 0; i < 6; i++) begin
      check_val("no_rsp_after_rst", rsp_valid, 0);
      step();
    end
    do_op(OP_ADD, 8'd55, 8'd3, 1'b1, 0);

    for (int i = 0; i < 18; i++) begin
      do_op(3'($urandom_range(6, 0)), 8'($urandom), 8'($urandom), 1'($urandom),
            int'($urandom_range(1, 0)));
    end

`ifdef STICKY_FLAGS_EN
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    m_sticky = '0;
    check_val("sticky_clr_idle", sticky_flags, 0);
    do_op(OP_ADD, 8'd200, 8'd100, 1'b0, 0);
    do_op(OP_ADD, 8'd1, 8'd2, 1'b0, 1);
    check_val("sticky_carry_kept", sticky_flags[0], 1);
    clr_at_cap = 1'b1;
    do_op(OP_ADD, 8'd255, 8'd255, 1'b0, 0);
    clr_at_cap = 1'b0;
    do_op(OP_ADD, 8'd128, 8'd128, 1'b0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
